// File: rtl/fft_result_sink_pkg.sv
// Shared definitions for the FFT result sink: capture FSM state encoding.
package fft_result_sink_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CAPTURE  = 2'd1,
        ST_WAIT_LOW = 2'd2
    } sink_state_t;

endpackage

// File: rtl/fft_result_sink_mag.sv
// Registered |I|+|Q| stage for one bin; a side tag travels alongside the magnitude.
module fft_mag_abs #(
    parameter int DATA_WIDTH = 8,
    parameter int TAG_W      = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    vld_i,
    input  logic [2*DATA_WIDTH-1:0] iq_i,
    input  logic [TAG_W-1:0]        tag_i,
    output logic                    vld_o,
    output logic [DATA_WIDTH:0]     mag_o,
    output logic [TAG_W-1:0]        tag_o
);
    localparam int DW = DATA_WIDTH;

    logic [DW-1:0] i_s, q_s, abs_i, abs_q;
    logic [DW:0]   mag_d, mag_q;
    logic          vld_q;
    logic [TAG_W-1:0] tag_q;

    // Unsigned DW-bit magnitude: the most negative value maps to 2^(DW-1) exactly.
    always_comb begin
        i_s   = iq_i[2*DW-1:DW];
        q_s   = iq_i[DW-1:0];
        abs_i = i_s[DW-1] ? (~i_s + 1'b1) : i_s;
        abs_q = q_s[DW-1] ? (~q_s + 1'b1) : q_s;
        mag_d = {1'b0, abs_i} + {1'b0, abs_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            mag_q <= '0;
            tag_q <= '0;
        end else begin
            vld_q <= vld_i;
            mag_q <= mag_d;
            tag_q <= tag_i;
        end
    end

    assign vld_o = vld_q;
    assign mag_o = mag_q;
    assign tag_o = tag_q;
endmodule

// File: rtl/fft_result_sink.sv
// Captures FFT output frames into a ping-pong bin buffer, tracks the peak |I|+|Q| bin
// and serves the last committed frame through a 1-cycle-latency read port.
module fft_result_sink
    import fft_result_sink_pkg::*;
#(
    parameter int N          = 64,
    parameter int DATA_WIDTH = 8,
    parameter int EXCLUDE_DC = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_fft_data_flag,
    input  logic [2*DATA_WIDTH-1:0]           in_fft_data,
    input  logic                              rd_en,
    input  logic [$clog2(N/2)-1:0]            rd_addr,
    output logic [2*DATA_WIDTH-1:0]           rd_data,
    output logic                              rd_valid,
    output logic                              frame_done,
    output logic [$clog2(N/2)-1:0]            peak_bin,
    output logic [DATA_WIDTH:0]               peak_mag,
    output logic                              frame_err,
    output logic                              busy
);
    localparam int DW     = DATA_WIDTH;
    localparam int NB     = N / 2;
    localparam int BIN_AW = $clog2(NB);
    localparam logic [BIN_AW-1:0] LAST_IDX  = BIN_AW'(NB - 1);
    localparam logic [BIN_AW-1:0] FIRST_IDX = (EXCLUDE_DC != 0) ? BIN_AW'(1) : '0;

    sink_state_t       state_q, state_d;
    logic [BIN_AW-1:0] idx_q, idx_d;
    logic              flag_q;
    logic              wr_en, wr_last, err_d, err_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wr_en   = 1'b0;
        wr_last = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_fft_data_flag && !flag_q) begin
                    wr_en   = 1'b1;
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (in_fft_data_flag) begin
                    wr_en = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        wr_last = 1'b1;
                        idx_d   = '0;
                        state_d = ST_WAIT_LOW;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    // Flag dropped mid-frame: abandon the partial frame.
                    err_d   = 1'b1;
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_LOW: begin
                if (!in_fft_data_flag) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            flag_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            flag_q  <= in_fft_data_flag;
            err_q   <= err_d;
        end
    end

    // S1: register the accepted bin with its index and end-of-frame marker.
    logic              s1_vld_q, s1_last_q;
    logic [2*DW-1:0]   s1_iq_q;
    logic [BIN_AW-1:0] s1_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_iq_q   <= '0;
            s1_idx_q  <= '0;
        end else begin
            s1_vld_q  <= wr_en;
            s1_last_q <= wr_last;
            s1_iq_q   <= in_fft_data;
            s1_idx_q  <= idx_q;
        end
    end

    logic              s2_vld;
    logic [DW:0]       s2_mag;
    logic [BIN_AW:0]   s2_tag;
    logic [BIN_AW-1:0] s2_idx;
    logic              s2_last;

    fft_mag_abs #(.DATA_WIDTH(DW), .TAG_W(BIN_AW + 1)) u_mag (
        .clk   (clk),
        .rst_n (rst_n),
        .vld_i (s1_vld_q),
        .iq_i  (s1_iq_q),
        .tag_i ({s1_last_q, s1_idx_q}),
        .vld_o (s2_vld),
        .mag_o (s2_mag),
        .tag_o (s2_tag)
    );

    assign s2_idx  = s2_tag[BIN_AW-1:0];
    assign s2_last = s2_tag[BIN_AW];

    // Running max: first eligible bin seeds it, strictly-greater keeps the lowest index on ties.
    logic [DW:0]       max_mag_q, best_mag;
    logic [BIN_AW-1:0] max_idx_q, best_idx;
    logic [DW:0]       peak_mag_q;
    logic [BIN_AW-1:0] peak_bin_q;
    logic              eligible, take, commit, wbank_q, wsel;

    always_comb begin
        eligible = s2_vld && !((EXCLUDE_DC != 0) && (s2_idx == '0));
        take     = eligible && ((s2_idx == FIRST_IDX) || (s2_mag > max_mag_q));
        best_mag = take ? s2_mag : max_mag_q;
        best_idx = take ? s2_idx : max_idx_q;
        commit   = s2_vld && s2_last;
        // A new frame may start in the commit cycle; it must land in the freed bank.
        wsel     = wbank_q ^ commit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_mag_q  <= '0;
            max_idx_q  <= '0;
            peak_mag_q <= '0;
            peak_bin_q <= '0;
            wbank_q    <= 1'b0;
        end else begin
            max_mag_q <= best_mag;
            max_idx_q <= best_idx;
            if (commit) begin
                peak_mag_q <= best_mag;
                peak_bin_q <= best_idx;
                wbank_q    <= ~wbank_q;
            end
        end
    end

    logic [2*DW-1:0] mem0 [NB];
    logic [2*DW-1:0] mem1 [NB];

    always_ff @(posedge clk) begin
        if (wr_en && !wsel) mem0[idx_q] <= in_fft_data;
    end

    always_ff @(posedge clk) begin
        if (wr_en && wsel) mem1[idx_q] <= in_fft_data;
    end

    // Read bank is the one not being written; sampled before any swap this cycle.
    logic [2*DW-1:0] rd_data_q;
    logic            rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) rd_data_q <= wbank_q ? mem0[rd_addr] : mem1[rd_addr];
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign frame_done = commit;
    assign frame_err  = err_q;
    assign peak_bin   = peak_bin_q;
    assign peak_mag   = peak_mag_q;
    assign busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_fft_result_sink.sv
// Scoreboard bench: two sinks (EXCLUDE_DC=0 and 1) share one directed stimulus stream.
module tb_fft_result_sink;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flag = 1'b0;
    logic [15:0] din = '0;
    logic        rd_en = 1'b0;
    logic [4:0]  rd_addr = '0;

    logic [15:0] rdd0, rdd1;
    logic        rv0, rv1, fd0, fd1, fe0, fe1, bz0, bz1;
    logic [4:0]  pb0, pb1;
    logic [8:0]  pm0, pm1;

    always #5 clk = ~clk;

    fft_result_sink #(.N(64), .DATA_WIDTH(8), .EXCLUDE_DC(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_fft_data_flag(flag), .in_fft_data(din),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd0), .rd_valid(rv0),
        .frame_done(fd0), .peak_bin(pb0), .peak_mag(pm0), .frame_err(fe0), .busy(bz0));

    fft_result_sink #(.N(64), .DATA_WIDTH(8), .EXCLUDE_DC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_fft_data_flag(flag), .in_fft_data(din),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd1), .rd_valid(rv1),
        .frame_done(fd1), .peak_bin(pb1), .peak_mag(pm1), .frame_err(fe1), .busy(bz1));

    typedef struct packed {
        logic [4:0] b0;
        logic [8:0] m0;
        logic [4:0] b1;
        logic [8:0] m1;
    } peak_t;

    peak_t       done_q[$];
    logic [15:0] rd_q[$];
    int          err_exp = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  bi[64];
    logic [7:0]  bq[64];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUTs present an output event.
    peak_t cur;
    bit    peak_pend = 1'b0;
    always @(negedge clk) begin
        if (peak_pend) begin
            chk("peak_dc_incl", {pb0, pm0}, {cur.b0, cur.m0});
            chk("peak_dc_excl", {pb1, pm1}, {cur.b1, cur.m1});
            peak_pend = 1'b0;
        end
        if (fd0 || fd1) begin
            chk("frame_done_both", {fd0, fd1}, 2'b11);
            chk("frame_done_expected", done_q.size() > 0, 1'b1);
            if (done_q.size() > 0) begin
                cur = done_q.pop_front();
                peak_pend = 1'b1;
            end
        end
        if (fe0 || fe1) begin
            chk("frame_err_both", {fe0, fe1}, 2'b11);
            chk("frame_err_expected", err_exp > 0, 1'b1);
            if (err_exp > 0) err_exp--;
        end
        if (rv0 || rv1) begin
            chk("rd_valid_both", {rv0, rv1}, 2'b11);
            chk("rd_expected", rd_q.size() > 0, 1'b1);
            if (rd_q.size() > 0) begin
                logic [15:0] e;
                e = rd_q.pop_front();
                chk("rd_data_dc_incl", rdd0, e);
                chk("rd_data_dc_excl", rdd1, e);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        flag = 1'b0;
        din  = '0;
        repeat (n) cyc();
    endtask

    task automatic clr_bins();
        for (int k = 0; k < 64; k++) begin
            bi[k] = '0;
            bq[k] = '0;
        end
    endtask

    task automatic send(input int n);
        for (int k = 0; k < n; k++) begin
            flag = 1'b1;
            din  = {bi[k], bq[k]};
            cyc();
        end
        flag = 1'b0;
        din  = '0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [15:0] e);
        rd_en   = 1'b1;
        rd_addr = a;
        rd_q.push_back(e);
        cyc();
        rd_en = 1'b0;
    endtask

    task automatic exp_done(input logic [4:0] b0, input logic [8:0] m0,
                            input logic [4:0] b1, input logic [8:0] m1);
        peak_t p;
        p.b0 = b0; p.m0 = m0; p.b1 = b1; p.m1 = m1;
        done_q.push_back(p);
    endtask

    task automatic check_zero(input string name);
        chk(name, {rdd0, rv0, fd0, pb0, pm0, fe0, bz0, rdd1, rv1, fd1, pb1, pm1, fe1, bz1}, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) cyc();
        check_zero("reset_outputs");
        rst_n = 1'b1;
        idle(2);

        // Frame 1: bin k = {k, -k}, magnitude 2k.
        clr_bins();
        for (int k = 0; k < 32; k++) begin
            bi[k] = 8'(k);
            bq[k] = 8'(-k);
        end
        exp_done(5'd31, 9'd62, 5'd31, 9'd62);
        send(32);
        chk("f1_done_not_yet", {fd0, fd1}, 2'b00);
        chk("f1_busy_waitlow", {bz0, bz1}, 2'b11);
        cyc();
        chk("f1_done_2_after_last", {fd0, fd1}, 2'b11);
        chk("f1_idle_after", {bz0, bz1}, 2'b00);
        idle(3);
        rd(5'd5, {8'd5, 8'hFB});
        idle(2);

        // Frame 2: tie between bins 3 and 20; read in the swap cycle sees frame 1.
        clr_bins();
        bi[3]  = 8'h80;
        bi[20] = 8'h80;
        exp_done(5'd3, 9'd128, 5'd3, 9'd128);
        send(32);
        cyc();
        rd(5'd5, {8'd5, 8'hFB});
        idle(3);
        rd(5'd5, 16'h0000);
        rd(5'd3, 16'h8000);
        idle(2);

        // Frame 3: flag drops after 10 bins.
        for (int k = 0; k < 32; k++) begin
            bi[k] = 8'h7F;
            bq[k] = 8'h7F;
        end
        err_exp++;
        send(10);
        chk("f3_err_not_yet", {fe0, fe1}, 2'b00);
        cyc();
        chk("f3_err_pulse", {fe0, fe1}, 2'b11);
        idle(3);
        chk("f3_peak_kept", {pb0, pm0, pb1, pm1}, {5'd3, 9'd128, 5'd3, 9'd128});
        rd(5'd3, 16'h8000);
        rd(5'd4, 16'h0000);
        idle(2);

        // Frame 4: flag held for 40 bins, then one low cycle and a fresh frame.
        clr_bins();
        for (int k = 0; k < 32; k++) bi[k] = 8'(k);
        for (int k = 32; k < 40; k++) begin
            bi[k] = 8'h7F;
            bq[k] = 8'h7F;
        end
        exp_done(5'd31, 9'd31, 5'd31, 9'd31);
        send(40);
        chk("f4_busy_until_low", {bz0, bz1}, 2'b11);
        cyc();
        chk("f4_idle_after_low", {bz0, bz1}, 2'b00);
        for (int k = 0; k < 32; k++) begin
            bi[k] = 8'h01;
            bq[k] = 8'h01;
        end
        bi[9] = 8'hCE;
        bq[9] = 8'h14;
        exp_done(5'd9, 9'd70, 5'd9, 9'd70);
        send(32);
        idle(4);
        rd(5'd9, 16'hCE14);
        rd(5'd0, 16'h0101);
        idle(2);

        // Frame 5: large DC bin; only the EXCLUDE_DC sink skips it.
        clr_bins();
        bi[0] = 8'd100;
        bq[0] = 8'd100;
        bi[7] = 8'd10;
        exp_done(5'd0, 9'd200, 5'd7, 9'd10);
        send(32);
        idle(4);

        // Frame 6: reset during bin 15, then a full frame bin k = {k-16, 3}.
        for (int k = 0; k < 32; k++) begin
            bi[k] = 8'(k - 16);
            bq[k] = 8'd3;
        end
        for (int k = 0; k < 15; k++) begin
            flag = 1'b1;
            din  = {bi[k], bq[k]};
            cyc();
        end
        din = {bi[15], bq[15]};
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset_outputs");
        flag = 1'b0;
        din  = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
        idle(2);
        check_zero("post_reset_outputs");
        exp_done(5'd0, 9'd19, 5'd1, 9'd18);
        send(32);
        idle(4);
        rd(5'd0, 16'hF003);
        rd(5'd31, 16'h0F03);
        idle(10);

        chk("done_queue_drained", done_q.size(), 0);
        chk("rd_queue_drained", rd_q.size(), 0);
        chk("err_expect_drained", err_exp, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
